// File: rtl/rs_entry_allocator_pkg.sv
// -----------------------------------------------------------------------------
// rs_entry_allocator_pkg
// Core-wide reservation-station sizing shared by Dispatch, the entry allocator
// and the Wakeup array.
//   RS_ENTRIES : number of RS entries (power of two, >= 2)
//   rs_idx_t   : type of an RS entry index
//   rs_cnt_t   : type of an occupancy count (0 .. RS_ENTRIES inclusive)
// -----------------------------------------------------------------------------
package rs_entry_allocator_pkg;

    localparam int RS_ENTRIES = 16;

    typedef logic [$clog2(RS_ENTRIES)-1:0]   rs_idx_t;
    typedef logic [$clog2(RS_ENTRIES+1)-1:0] rs_cnt_t;

endpackage

// File: rtl/rs_entry_allocator_lsb_prio_enc.sv
// -----------------------------------------------------------------------------
// rs_entry_allocator_lsb_prio_enc
// Parameterized lowest-set-bit priority encoder, shared with Wakeup select.
//   req_i   [WIDTH]     : request vector
//   idx_o   [IDX_WIDTH] : index of the lowest set bit of req_i (0 if none)
//   found_o             : at least one bit of req_i is set
// -----------------------------------------------------------------------------
module rs_entry_allocator_lsb_prio_enc #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 found_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_WIDTH'(i);
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/rs_entry_allocator.sv
// -----------------------------------------------------------------------------
// rs_entry_allocator
// Reservation-station entry allocator between Dispatch and the Wakeup array.
// Keeps a busy bitmap, offers the lowest free entry each cycle, reclaims
// entries issued by Wakeup and clears everything on flush.
//
// Ports
//   clk_i           : core clock, all state on the rising edge
//   rst_ni          : asynchronous active-low reset
//   alloc_req_i     : Dispatch claims the offered entry (dispatch_valid)
//   entry_free_o    : an entry is on offer
//   entry_index_o   : lowest-numbered free entry (0 and meaningless when full)
//   rel_valid_i     : Wakeup issued an entry this cycle
//   rel_index_i     : index of the issued entry
//   flush_i         : squash, free all entries
//   occupancy_o     : number of busy entries
//   full_o          : occupancy == RS_ENTRIES
//   empty_o         : occupancy == 0
//   alloc_drop_o    : one-cycle pulse, alloc_req_i arrived with nothing free
//   dbl_free_err_o  : one-cycle pulse, release of an entry that was not busy
//
// Handshake (Wakeup side of WakeupDispatchIF): entry_free_o is the valid of an
// offer carrying entry_index_o; alloc_req_i is the taker. An allocation
// commits at the rising edge where alloc_req_i && entry_free_o. The offer
// depends only on registered state, so it never reacts to alloc_req_i within
// the same cycle; alloc_req_i without an offer is dropped and reported.
// -----------------------------------------------------------------------------
module rs_entry_allocator
    import rs_entry_allocator_pkg::*;
#(
    parameter int RS_ENTRIES_P = RS_ENTRIES,
    parameter int RS_IDX_WIDTH = $clog2(RS_ENTRIES_P),
    parameter int CNT_WIDTH    = $clog2(RS_ENTRIES_P + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_req_i,
    output logic                    entry_free_o,
    output logic [RS_IDX_WIDTH-1:0] entry_index_o,
    input  logic                    rel_valid_i,
    input  logic [RS_IDX_WIDTH-1:0] rel_index_i,
    input  logic                    flush_i,
    output logic [CNT_WIDTH-1:0]    occupancy_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    alloc_drop_o,
    output logic                    dbl_free_err_o
);

    logic [RS_ENTRIES_P-1:0] busy_q, busy_d;
    logic [CNT_WIDTH-1:0]    occ_q, occ_d;
    logic                    alloc_drop_q, alloc_drop_d;
    logic                    dbl_free_q, dbl_free_d;

    logic alloc_ok;
    logic rel_ok;
    logic rel_hit;

    // Offer: lowest free entry, purely from registered busy state.
    rs_entry_allocator_lsb_prio_enc #(
        .WIDTH     (RS_ENTRIES_P),
        .IDX_WIDTH (RS_IDX_WIDTH)
    ) u_free_enc (
        .req_i   (~busy_q),
        .idx_o   (entry_index_o),
        .found_o (entry_free_o)
    );

    assign rel_hit  = busy_q[rel_index_i];
    // Flush overrides everything, including the error/drop reporting.
    assign alloc_ok = alloc_req_i && entry_free_o && !flush_i;
    assign rel_ok   = rel_valid_i && rel_hit && !flush_i;

    always_comb begin
        busy_d       = busy_q;
        occ_d        = occ_q + CNT_WIDTH'(alloc_ok) - CNT_WIDTH'(rel_ok);
        alloc_drop_d = alloc_req_i && !entry_free_o && !flush_i;
        dbl_free_d   = rel_valid_i && !rel_hit && !flush_i;
        // The offered entry is never busy, so a release can never hit it in
        // the same cycle; the two updates touch different bits.
        if (alloc_ok) begin
            busy_d[entry_index_o] = 1'b1;
        end
        if (rel_ok) begin
            busy_d[rel_index_i] = 1'b0;
        end
        if (flush_i) begin
            busy_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= '0;
            occ_q        <= '0;
            alloc_drop_q <= 1'b0;
            dbl_free_q   <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            occ_q        <= occ_d;
            alloc_drop_q <= alloc_drop_d;
            dbl_free_q   <= dbl_free_d;
        end
    end

    assign occupancy_o    = occ_q;
    assign full_o         = (occ_q == CNT_WIDTH'(RS_ENTRIES_P));
    assign empty_o        = (occ_q == '0);
    assign alloc_drop_o   = alloc_drop_q;
    assign dbl_free_err_o = dbl_free_q;

    // The counter is a cached popcount of the bitmap; they must never diverge.
    a_occ_matches_busy: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        occ_q == CNT_WIDTH'($countones(busy_q))
    );

    a_occ_in_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        occ_q <= CNT_WIDTH'(RS_ENTRIES_P)
    );

endmodule

// File: tb/tb_rs_entry_allocator.sv
// -----------------------------------------------------------------------------
// tb_rs_entry_allocator
// Self-checking bench for rs_entry_allocator (16 entries): a table of directed
// vectors, an ordered-offer sequence, an asynchronous reset sequence and a
// randomized alloc/release/flush run checked against a bitmap model.
// -----------------------------------------------------------------------------
module tb_rs_entry_allocator;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       rel_valid = 1'b0;
    logic [3:0] rel_index = '0;
    logic       flush = 1'b0;

    logic       entry_free;
    logic [3:0] entry_index;
    logic [4:0] occupancy;
    logic       full;
    logic       empty;
    logic       alloc_drop;
    logic       dbl_free_err;

    always #5 clk = ~clk;

    rs_entry_allocator dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .alloc_req_i    (alloc_req),
        .entry_free_o   (entry_free),
        .entry_index_o  (entry_index),
        .rel_valid_i    (rel_valid),
        .rel_index_i    (rel_index),
        .flush_i        (flush),
        .occupancy_o    (occupancy),
        .full_o         (full),
        .empty_o        (empty),
        .alloc_drop_o   (alloc_drop),
        .dbl_free_err_o (dbl_free_err)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_free, input logic [3:0] e_idx,
                             input logic [4:0] e_occ, input logic e_full, input logic e_empty,
                             input logic e_drop, input logic e_dbl);
        check({tag, ".entry_free"},   32'(entry_free),   32'(e_free));
        check({tag, ".entry_index"},  32'(entry_index),  32'(e_idx));
        check({tag, ".occupancy"},    32'(occupancy),    32'(e_occ));
        check({tag, ".full"},         32'(full),         32'(e_full));
        check({tag, ".empty"},        32'(empty),        32'(e_empty));
        check({tag, ".alloc_drop"},   32'(alloc_drop),   32'(e_drop));
        check({tag, ".dbl_free_err"}, 32'(dbl_free_err), 32'(e_dbl));
    endtask

    // ---------------- directed vector table ----------------
    // Inputs are held for one rising edge; expectations are the outputs
    // sampled 1 time unit after that edge.
    typedef struct {
        logic       alloc;
        logic       rel_v;
        logic [3:0] rel_idx;
        logic       flush;
        logic       e_free;
        logic [3:0] e_idx;
        logic [4:0] e_occ;
        logic       e_full;
        logic       e_empty;
        logic       e_drop;
        logic       e_dbl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic a, input logic rv, input logic [3:0] ri, input logic fl,
                                input logic ef, input logic [3:0] ei, input logic [4:0] eo,
                                input logic efu, input logic eem, input logic edr, input logic edb);
        vec_t v;
        v.alloc = a;  v.rel_v = rv; v.rel_idx = ri; v.flush = fl;
        v.e_free = ef; v.e_idx = ei; v.e_occ = eo; v.e_full = efu;
        v.e_empty = eem; v.e_drop = edr; v.e_dbl = edb;
        vecs.push_back(v);
    endfunction

    task automatic drive_idle();
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_index = '0;
        flush     = 1'b0;
    endtask

    // ---------------- random-phase model ----------------
    logic [15:0] m_busy;

    function automatic logic [3:0] m_lowest_free(input logic [15:0] b);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (!b[i]) r = 4'(i);
        end
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        // 16 allocations from empty: offers 0..15 in order, full after the last.
        for (int i = 0; i < 16; i++) begin
            add(1, 0, 0, 0, (i != 15), (i == 15) ? 4'd0 : 4'(i + 1), 5'(i + 1), (i == 15), 0, 0, 0);
        end
        add(1, 0, 0, 0, 0, 0, 16, 1, 0, 1, 0);   // 17th request: dropped
        add(0, 0, 0, 0, 0, 0, 16, 1, 0, 0, 0);   // drop pulse lasts one cycle
        add(0, 1, 5, 0, 1, 5, 15, 0, 0, 0, 0);   // release 5 from full
        add(0, 1, 3, 0, 1, 3, 14, 0, 0, 0, 0);   // release 3 -> offer 3
        add(0, 1, 4, 0, 1, 3, 13, 0, 0, 0, 0);   // release 4 -> offer still 3
        add(1, 1, 9, 0, 1, 4, 13, 0, 0, 0, 0);   // alloc 3 + release 9: occ same, offer 4
        add(0, 1, 9, 0, 1, 4, 13, 0, 0, 0, 1);   // 9 already free -> dbl_free_err
        add(0, 0, 0, 0, 1, 4, 13, 0, 0, 0, 0);   // error pulse lasts one cycle
        add(1, 1, 5, 0, 1, 5, 14, 0, 0, 0, 1);   // alloc 4 + bogus release 5
        add(1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);    // flush wins over alloc/release
        add(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1);    // release of the offered entry is invalid
        add(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);    // release 0 -> empty again

        // Reset state.
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1, 0, 0, 0, 1, 0, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_idle", 1, 0, 0, 0, 1, 0, 0);

        // Table.
        foreach (vecs[n]) begin
            alloc_req = vecs[n].alloc;
            rel_valid = vecs[n].rel_v;
            rel_index = vecs[n].rel_idx;
            flush     = vecs[n].flush;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", n), vecs[n].e_free, vecs[n].e_idx, vecs[n].e_occ,
                      vecs[n].e_full, vecs[n].e_empty, vecs[n].e_drop, vecs[n].e_dbl);
            drive_idle();
        end

        // Offer order seen before each commit edge, back to back.
        for (int i = 0; i < 4; i++) exp_q.push_back(4'(i));
        alloc_req = 1'b1;
        while (exp_q.size() > 0) begin
            check("offer_order", 32'(entry_index), 32'(exp_q.pop_front()));
            @(posedge clk);
            #1;
        end
        alloc_req = 1'b0;
        check("offer_order.occ", 32'(occupancy), 32'd4);

        // Asynchronous reset mid-operation with a pending request.
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_index = 4'd2;
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 1, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        check_all("async_reset_held", 1, 0, 0, 0, 1, 0, 0);
        drive_idle();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized alloc/release/flush against a bitmap model, with one
        // asynchronous reset in the middle.
        m_busy = '0;
        for (int c = 0; c < 6000; c++) begin
            logic       a, rv, fl, m_free, e_drop, e_dbl, a_ok, r_ok;
            logic [3:0] ri, m_idx;
            if (c == 3000) begin
                alloc_req = 1'b1;
                #1 rst_n = 1'b0;
                #1;
                check_all("rand_async_reset", 1, 0, 0, 0, 1, 0, 0);
                drive_idle();
                #1 rst_n = 1'b1;
                m_busy = '0;
            end
            a  = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 50);
            ri = 4'($urandom_range(0, 15));
            fl = ($urandom_range(0, 99) < 2);
            m_free = ~&m_busy;
            m_idx  = m_free ? m_lowest_free(m_busy) : 4'd0;
            check("rand.entry_free", 32'(entry_free), 32'(m_free));
            check("rand.entry_index", 32'(entry_index), 32'(m_idx));
            alloc_req = a;
            rel_valid = rv;
            rel_index = ri;
            flush     = fl;
            a_ok   = a && m_free && !fl;
            r_ok   = rv && m_busy[ri] && !fl;
            e_drop = a && !m_free && !fl;
            e_dbl  = rv && !m_busy[ri] && !fl;
            if (a_ok) m_busy[m_idx] = 1'b1;
            if (r_ok) m_busy[ri] = 1'b0;
            if (fl) m_busy = '0;
            @(posedge clk);
            #1;
            check("rand.occupancy", 32'(occupancy), 32'($countones(m_busy)));
            check("rand.full", 32'(full), 32'(&m_busy));
            check("rand.empty", 32'(empty), 32'(m_busy == '0));
            check("rand.alloc_drop", 32'(alloc_drop), 32'(e_drop));
            check("rand.dbl_free_err", 32'(dbl_free_err), 32'(e_dbl));
            drive_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
